// File: rtl/bpsk_modulator_pkg.sv
// Shared definitions for the BPSK modulator: state encoding, default symbol
// length and the phase-counter width helper.
package bpsk_modulator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int CPS_DEFAULT = 256;

  function automatic int cnt_width(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/bpsk_modulator_if.sv
// Data-bit handshake, carrier input and modulated output of the BPSK modulator.
interface bpsk_modulator_if;
  logic signed [15:0] carrier_sig;
  logic               bit_sig;
  logic               bit_valid;
  logic               bit_ready;
  logic signed [15:0] mod_sig;
  logic               mod_valid;
  logic               sym_start;
  logic               underrun;

  modport slave (
    input  carrier_sig, bit_sig, bit_valid,
    output bit_ready, mod_sig, mod_valid, sym_start, underrun
  );

  modport master (
    output carrier_sig, bit_sig, bit_valid,
    input  bit_ready, mod_sig, mod_valid, sym_start, underrun
  );
endinterface

// File: rtl/bpsk_modulator_counter.sv
// Free-running modulo-NUM counter; carry is high on the last count (NUM-1).
module bpsk_modulator_counter
  import bpsk_modulator_pkg::*;
#(
  parameter int NUM = CPS_DEFAULT,
  localparam int W  = cnt_width(NUM)
) (
  input  logic         clk_sig,
  input  logic         rst_n,
  output logic [W-1:0] count,
  output logic         carry
);

  localparam logic [W-1:0] LAST = W'(NUM - 1);

  assign carry = (count == LAST);

  always_ff @(posedge clk_sig) begin
    if (!rst_n)     count <= '0;
    else if (carry) count <= '0;
    else            count <= count + 1'b1;
  end

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK modulator: one data bit per carrier period, symbols switch only on
// the phase-counter wrap so each symbol starts at carrier phase 0.
//
// state | meaning
// IDLE  | no symbol on air, output held at zero
// RUN   | cur_bit on air, carrier passed through or inverted
module bpsk_modulator
  import bpsk_modulator_pkg::*;
#(
  parameter int CYCLES_PER_SYMBOL = CPS_DEFAULT
) (
  input logic             clk_sig,
  input logic             rst_n,
  bpsk_modulator_if.slave bus
);

  localparam int CW = cnt_width(CYCLES_PER_SYMBOL);

  logic [CW-1:0]      phase;
  logic               boundary;
  state_t             state, state_d;
  logic               cur_bit, cur_bit_d;
  logic               next_bit, next_bit_d;
  logic               next_full, next_full_d;
  logic               ready_q;
  logic               xfer;
  logic               underrun_d;
  logic signed [15:0] mod_q;
  logic               mod_valid_q, sym_start_q, underrun_q;

  bpsk_modulator_counter #(.NUM(CYCLES_PER_SYMBOL)) u_phase (
    .clk_sig (clk_sig),
    .rst_n   (rst_n),
    .count   (phase),
    .carry   (boundary)
  );

  // ready is only ever granted from a register so valid cannot loop back into it
  assign xfer          = bus.bit_valid & ready_q;
  assign bus.bit_ready = ready_q;

  always_ff @(posedge clk_sig) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_bit   <= 1'b0;
      next_bit  <= 1'b0;
      next_full <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state     <= state_d;
      cur_bit   <= cur_bit_d;
      next_bit  <= next_bit_d;
      next_full <= next_full_d;
      ready_q   <= ~next_full_d;
    end
  end

  always_comb begin
    state_d     = state;
    cur_bit_d   = cur_bit;
    next_bit_d  = next_bit;
    next_full_d = next_full;
    underrun_d  = 1'b0;
    if (boundary) begin
      if (next_full) begin
        cur_bit_d   = next_bit;
        next_full_d = 1'b0;
        state_d     = RUN;
      end else if (xfer) begin
        cur_bit_d = bus.bit_sig;
        state_d   = RUN;
      end else begin
        state_d    = IDLE;
        underrun_d = (state == RUN);
      end
    end else if (xfer) begin
      next_bit_d  = bus.bit_sig;
      next_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sig) begin
    if (!rst_n) begin
      mod_q       <= 16'sd0;
      mod_valid_q <= 1'b0;
      sym_start_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      mod_valid_q <= (state == RUN);
      sym_start_q <= (state == RUN) && (phase == '0);
      underrun_q  <= underrun_d;
      if (state == RUN) mod_q <= cur_bit ? bus.carrier_sig : -bus.carrier_sig;
      else              mod_q <= 16'sd0;
    end
  end

  assign bus.mod_sig   = mod_q;
  assign bus.mod_valid = mod_valid_q;
  assign bus.sym_start = sym_start_q;
  assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_bpsk_modulator.sv
// Directed bench for bpsk_modulator: a per-cycle expectation queue plus a
// queue of accepted bits checked against each symbol's first sample.
module tb_bpsk_modulator;
  import bpsk_modulator_pkg::*;

  localparam int N = 256;

  logic clk_sig = 1'b0;
  logic rst_n;

  bpsk_modulator_if bus ();

  bpsk_modulator #(.CYCLES_PER_SYMBOL(N)) dut (
    .clk_sig (clk_sig),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_sig = ~clk_sig;

  int checks = 0;
  int errors = 0;

  // reference model state
  int   ph;
  logic st, cur, nf, nb, rdy;

  logic [19:0] expq[$];
  logic        symq[$];

  int k_rel, acc_cnt, sym_cnt, und_cnt, valid_cnt, run_len, max_run, first_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    k_rel = 0; acc_cnt = 0; sym_cnt = 0; und_cnt = 0; valid_cnt = 0;
    run_len = 0; max_run = 0; first_valid = -1;
  endtask

  task automatic cyc(input logic r, input logic bv, input logic bs, input logic signed [15:0] car);
    logic               xfer, ss, und, vld;
    logic signed [15:0] m;
    logic [19:0]        e;
    logic               b;
    rst_n           = r;
    bus.bit_valid   = bv;
    bus.bit_sig     = bs;
    bus.carrier_sig = car;
    if (r && bv && bus.bit_ready) acc_cnt++;
    if (!r) begin
      e = '0;
      ph = 0; st = 1'b0; cur = 1'b0; nf = 1'b0; nb = 1'b0; rdy = 1'b0;
      symq.delete();
    end else begin
      k_rel++;
      xfer = bv && rdy;
      vld  = st;
      ss   = st && (ph == 0);
      und  = (ph == N - 1) && st && !nf && !xfer;
      m    = st ? (cur ? car : -car) : 16'sd0;
      if (xfer) symq.push_back(bs);
      if (ph == N - 1) begin
        if (nf) begin cur = nb; nf = 1'b0; st = 1'b1; end
        else if (xfer) begin cur = bs; st = 1'b1; end
        else st = 1'b0;
        ph = 0;
      end else begin
        if (xfer) begin nf = 1'b1; nb = bs; end
        ph = ph + 1;
      end
      rdy = !nf;
      e = {rdy, vld, ss, und, m};
    end
    expq.push_back(e);
    @(posedge clk_sig);
    #1;
    chk("cycle", {bus.bit_ready, bus.mod_valid, bus.sym_start, bus.underrun, bus.mod_sig},
        expq.pop_front());
    if (r) begin
      if (bus.sym_start) begin
        sym_cnt++;
        if (symq.size() == 0) begin
          checks++; errors++;
          $error("FAIL sym_value observed=sym_start expected=no symbol (no bit queued)");
        end else begin
          b = symq.pop_front();
          chk("sym_value", bus.mod_sig, b ? car : -car);
        end
      end
      if (bus.underrun) und_cnt++;
      if (bus.mod_valid) begin
        valid_cnt++;
        run_len++;
        if (first_valid < 0) first_valid = k_rel;
        if (run_len > max_run) max_run = run_len;
      end else run_len = 0;
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'sd0);
    clear_stats();
  endtask

  logic bits3[3];
  int   idx;
  logic hs;

  initial begin
    rst_n = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_sig = 1'b0;
    bus.carrier_sig = 16'sd0;
    clear_stats();

    // reset values and ramp carrier with a single bit offered at cycle 10
    do_reset(3);
    chk("reset_outputs", {bus.bit_ready, bus.mod_valid, bus.sym_start, bus.underrun, bus.mod_sig}, 20'h0);
    for (int k = 1; k <= 600; k++) begin
      cyc(1'b1, (k == 10), 1'b1, 16'(k * 7));
      if (k == 1) chk("ready_after_release", bus.bit_ready, 1);
    end
    chk("ramp_first_valid", first_valid, 257);
    chk("ramp_sym_count", sym_cnt, 1);
    chk("ramp_underrun_count", und_cnt, 1);

    // bits 1,0,1 back to back, constant carrier
    do_reset(2);
    bits3[0] = 1'b1; bits3[1] = 1'b0; bits3[2] = 1'b1;
    idx = 0;
    for (int k = 1; k <= 1100; k++) begin
      hs = (idx < 3) && bus.bit_ready;
      cyc(1'b1, (idx < 3), (idx < 3) ? bits3[idx] : 1'b0, 16'sd1000);
      if (hs) idx++;
      if (k == 300) chk("b2b_sym1", bus.mod_sig, 16'sd1000);
      if (k == 600) chk("b2b_sym2", bus.mod_sig, -16'sd1000);
      if (k == 900) chk("b2b_sym3", bus.mod_sig, 16'sd1000);
    end
    chk("b2b_sym_count", sym_cnt, 3);
    chk("b2b_continuous_run", max_run, 768);
    chk("b2b_underrun_count", und_cnt, 1);

    // full-scale negative carrier with bit 0
    do_reset(2);
    for (int k = 1; k <= 530; k++) begin
      cyc(1'b1, (k == 3), 1'b0, -16'sd32767);
      if (k == 300) chk("fullscale_neg", bus.mod_sig, 16'sd32767);
    end

    // bit_valid held high: one acceptance per symbol
    do_reset(2);
    for (int k = 1; k <= 1030; k++) begin
      cyc(1'b1, 1'b1, (k % 2) == 1, 16'sd1234);
      if (k == 2) chk("hold_ready_drop", bus.bit_ready, 0);
      if (k == 256) chk("hold_ready_rise", bus.bit_ready, 1);
    end
    chk("hold_accept_count", acc_cnt, 5);
    chk("hold_continuous_run", max_run, 774);

    // bit offered exactly on the boundary while idle
    do_reset(2);
    for (int k = 1; k <= 600; k++) begin
      cyc(1'b1, (k == 256), 1'b0, 16'sd500);
      if (k == 256) chk("bypass_ready_kept", bus.bit_ready, 1);
      if (k == 257) chk("bypass_run_next", {bus.mod_valid, bus.sym_start}, 2'b11);
    end
    chk("bypass_accept_count", acc_cnt, 1);
    chk("bypass_underrun_count", und_cnt, 1);

    // reset mid-symbol with a held bit
    do_reset(2);
    for (int k = 1; k <= 356; k++) cyc(1'b1, (k == 5 || k == 300), 1'b1, 16'sd700);
    chk("abort_pre_valid", bus.mod_valid, 1);
    cyc(1'b0, 1'b0, 1'b0, 16'sd700);
    chk("abort_outputs_zero", {bus.bit_ready, bus.mod_valid, bus.sym_start, bus.underrun, bus.mod_sig}, 20'h0);
    do_reset(1);
    for (int k = 1; k <= 600; k++) cyc(1'b1, 1'b0, 1'b0, 16'sd700);
    chk("abort_no_symbol", valid_cnt, 0);
    chk("abort_no_sym_start", sym_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
